// File: rtl/ysyx_23060187_sim_monitor_if.sv
// Dump stream of the simulation monitor: one snapshot word per handshake.
interface ysyx_23060187_sim_monitor_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
);
  logic              dump_valid;
  logic              dump_ready;
  logic [IDX_W-1:0]  dump_idx;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    output dump_ready
  );
endinterface

// File: rtl/ysyx_23060187_sim_monitor.sv
// Run-control and result-dump monitor: counts run cycles, detects end of run
// (ebreak, PC self-loop, timeout), snapshots the watched channels and streams
// them out one word per handshake.
module ysyx_23060187_sim_monitor #(
  parameter int              NUM_WATCH   = 8,
  parameter int              DATA_W      = 32,
  parameter longint unsigned TIMEOUT_CYC = 64'd10000000,
  parameter int              LOOP_CYC    = 4,
  parameter int              CNT_W       = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [31:0]                 pc,
  input  logic                        halt_req,
  input  logic [NUM_WATCH*DATA_W-1:0] watch_bus,
  ysyx_23060187_sim_monitor_if.master dump,
  output logic                        running,
  output logic                        done,
  output logic [1:0]                  status,
  output logic [CNT_W-1:0]            cycle_cnt
);

  localparam int IDX_W = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1;
  localparam int LP_W  = $clog2(LOOP_CYC) + 1;
  // Compared in 64 bits so an unreachable timeout simply never fires and the
  // counter saturates instead.
  localparam logic [63:0] TO_LAST = 64'(TIMEOUT_CYC - 64'd1);

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_EBRK = 2'b01;
  localparam logic [1:0] ST_LOOP = 2'b10;
  localparam logic [1:0] ST_TMO  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DUMP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [LP_W-1:0]   loop_q, loop_d;
  logic [31:0]       prev_pc_q, prev_pc_d;
  logic              first_q, first_d;
  logic [1:0]        status_q, status_d;
  logic [DATA_W-1:0] snap_q [NUM_WATCH];
  logic [DATA_W-1:0] snap_d [NUM_WATCH];
  logic              dump_valid_q, dump_valid_d;
  logic [IDX_W-1:0]  dump_idx_q, dump_idx_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;

  logic              pc_match;
  logic              loop_hit;
  logic              tmo_hit;
  logic              fire;
  logic              last_idx;
  logic [IDX_W-1:0]  nxt_idx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The first RUN cycle has no valid prev_pc, so it never counts as a repeat.
  assign pc_match = !first_q && (pc == prev_pc_q);
  assign loop_hit = pc_match && (loop_q == LP_W'(LOOP_CYC - 2));
  assign tmo_hit  = (64'(cycle_cnt_q) == TO_LAST);
  assign fire     = dump_valid_q && dump.dump_ready;
  assign last_idx = (dump_idx_q == IDX_W'(NUM_WATCH - 1));
  assign nxt_idx  = dump_idx_q + IDX_W'(1);

  // Next-state and next-output computation for the run/dump sequencer.
  always_comb begin
    state_d      = state_q;
    cycle_cnt_d  = cycle_cnt_q;
    loop_d       = loop_q;
    prev_pc_d    = prev_pc_q;
    first_d      = first_q;
    status_d     = status_q;
    snap_d       = snap_q;
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          cycle_cnt_d = '0;
          loop_d      = '0;
          first_d     = 1'b1;
          status_d    = ST_NONE;
        end
      end
      S_RUN: begin
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        prev_pc_d   = pc;
        first_d     = 1'b0;
        loop_d      = pc_match ? loop_q + LP_W'(1) : '0;
        if (halt_req || loop_hit || tmo_hit) begin
          state_d = S_DUMP;
          if (halt_req)      status_d = ST_EBRK;
          else if (loop_hit) status_d = ST_LOOP;
          else               status_d = ST_TMO;
          for (int k = 0; k < NUM_WATCH; k++) begin
            snap_d[k] = watch_bus[k*DATA_W +: DATA_W];
          end
          dump_valid_d = 1'b1;
          dump_idx_d   = '0;
          dump_data_d  = watch_bus[DATA_W-1:0];
        end
      end
      S_DUMP: begin
        if (fire) begin
          if (last_idx) begin
            state_d      = S_DONE;
            dump_valid_d = 1'b0;
          end else begin
            dump_idx_d  = nxt_idx;
            dump_data_d = snap_q[nxt_idx];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset wins over every event and abandons a partial dump.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cycle_cnt_q  <= '0;
      loop_q       <= '0;
      prev_pc_q    <= '0;
      first_q      <= 1'b0;
      status_q     <= ST_NONE;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
      for (int k = 0; k < NUM_WATCH; k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cycle_cnt_q  <= cycle_cnt_d;
      loop_q       <= loop_d;
      prev_pc_q    <= prev_pc_d;
      first_q      <= first_d;
      status_q     <= status_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
      snap_q       <= snap_d;
    end
  end

  assign running         = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign status          = status_q;
  assign cycle_cnt       = cycle_cnt_q;
  assign dump.dump_valid = dump_valid_q;
  assign dump.dump_idx   = dump_idx_q;
  assign dump.dump_data  = dump_data_q;

endmodule

// File: tb/tb_ysyx_23060187_sim_monitor.sv
// Bench for the simulation monitor: an 8x32 instance with short timeout and a
// 1x64 instance. Dump words are checked against a scoreboard queue.
module tb_ysyx_23060187_sim_monitor;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, halt_req;
  logic [31:0]  pc;
  logic [255:0] watch;
  logic         running, done;
  logic [1:0]   status;
  logic [31:0]  cycle_cnt;

  logic         start2, halt2;
  logic [31:0]  pc2;
  logic [63:0]  watch2;
  logic         running2, done2;
  logic [1:0]   status2;
  logic [31:0]  cycle_cnt2;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  ysyx_23060187_sim_monitor_if #(.DATA_W(32), .IDX_W(3)) dif ();
  ysyx_23060187_sim_monitor_if #(.DATA_W(64), .IDX_W(1)) dif2 ();

  ysyx_23060187_sim_monitor #(
    .NUM_WATCH(8), .DATA_W(32), .TIMEOUT_CYC(100), .LOOP_CYC(4), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .halt_req(halt_req),
    .watch_bus(watch), .dump(dif), .running(running), .done(done),
    .status(status), .cycle_cnt(cycle_cnt)
  );

  ysyx_23060187_sim_monitor #(
    .NUM_WATCH(1), .DATA_W(64), .TIMEOUT_CYC(1000), .LOOP_CYC(4), .CNT_W(32)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pc(pc2), .halt_req(halt2),
    .watch_bus(watch2), .dump(dif2), .running(running2), .done(done2),
    .status(status2), .cycle_cnt(cycle_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_watch(input logic [31:0] base);
    for (int k = 0; k < 8; k++) watch[k*32 +: 32] = base + 32'(k);
  endtask

  task automatic push_snapshot();
    sb_t e;
    for (int k = 0; k < 8; k++) begin
      e.idx  = 4'(k);
      e.data = watch[k*32 +: 32];
      sb.push_back(e);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_dump(input string tag, input int exp_cyc);
    int cyc = 0;
    while (!done && cyc < 64) begin
      tick();
      cyc++;
    end
    chk(tag, cyc, exp_cyc);
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_valid_off"}, dif.dump_valid, 0);
  endtask

  // Scoreboard consumer plus hold-while-stalled check, sampled mid-cycle.
  logic        hold_pend = 1'b0;
  logic [2:0]  hold_idx;
  logic [31:0] hold_data;
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_idx", dif.dump_idx, hold_idx);
        chk("hold_data", dif.dump_data, hold_data);
      end
      hold_pend = dif.dump_valid && !dif.dump_ready;
      hold_idx  = dif.dump_idx;
      hold_data = dif.dump_data;
      if (dif.dump_valid && dif.dump_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("dump_idx", dif.dump_idx, e.idx);
          chk("dump_data", dif.dump_data, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic rdy;
    rst = 1'b0; start = 1'b0; halt_req = 1'b0; pc = 32'h8000_0000; watch = '0;
    start2 = 1'b0; halt2 = 1'b0; pc2 = 32'h0; watch2 = '0;
    dif.dump_ready = 1'b0; dif2.dump_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("rst_valid", dif.dump_valid, 0);
    chk("rst_idx", dif.dump_idx, 0);
    chk("rst_data", dif.dump_data, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst2_valid", dif2.dump_valid, 0);

    // Ebreak on RUN cycle 50, full-speed dump.
    set_watch(32'h1000_0000);
    dif.dump_ready = 1'b1;
    do_start();
    chk("eb_running", running, 1);
    chk("eb_cnt0", cycle_cnt, 0);
    for (int c = 1; c < 50; c++) begin
      pc = pc + 32'd4;
      tick();
    end
    pc = pc + 32'd4;
    halt_req = 1'b1;
    push_snapshot();
    tick();
    halt_req = 1'b0;
    watch = {8{32'hDEAD_0000}};
    chk("eb_status", status, 2'b01);
    chk("eb_cnt", cycle_cnt, 50);
    chk("eb_running_off", running, 0);
    chk("eb_valid", dif.dump_valid, 1);
    wait_dump("eb_dump_cycles", 8);
    chk("eb_done", done, 1);
    chk("eb_cnt_hold", cycle_cnt, 50);

    // Timeout with pc always changing; a start pulse mid-run is ignored.
    set_watch(32'h2000_0000);
    dif.dump_ready = 1'b0;
    do_start();
    chk("to_status_clr", status, 0);
    chk("to_done_clr", done, 0);
    n = 0;
    while (running && n < 200) begin
      pc = pc + 32'd4;
      start = (n == 50);
      tick();
      n++;
    end
    start = 1'b0;
    push_snapshot();
    chk("to_run_cycles", n, 100);
    chk("to_status", status, 2'b11);
    chk("to_cnt", cycle_cnt, 100);
    // Backpressure: ready toggles, watch keeps changing after capture.
    rdy = 1'b1;
    n = 0;
    while (!done && n < 64) begin
      dif.dump_ready = rdy;
      watch = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
      rdy = !rdy;
    end
    chk("bp_dump_cycles", n, 15);
    chk("bp_sb_left", sb.size(), 0);

    // PC loop: pc steps by 4 then sticks at 0x8000_0040.
    set_watch(32'h3000_0000);
    dif.dump_ready = 1'b1;
    do_start();
    for (int c = 1; c <= 4; c++) begin
      pc = 32'h8000_0030 + 32'(4 * (c - 1));
      tick();
    end
    for (int c = 5; c <= 7; c++) begin
      pc = 32'h8000_0040;
      tick();
      chk("loop_still_running", running, 1);
    end
    push_snapshot();
    tick();
    chk("loop_status", status, 2'b10);
    chk("loop_cnt", cycle_cnt, 8);
    wait_dump("loop_dump_cycles", 8);

    // pc unchanged from previous run's last pc: first cycle must not match;
    // halt_req on the loop-detect cycle takes priority.
    set_watch(32'h4000_0000);
    do_start();
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("first_no_match", running, 1);
    end
    halt_req = 1'b1;
    push_snapshot();
    tick();
    halt_req = 1'b0;
    chk("prio_status", status, 2'b01);
    chk("prio_cnt", cycle_cnt, 4);
    wait_dump("prio_dump_cycles", 8);

    // Reset in the middle of a dump.
    set_watch(32'h5000_0000);
    do_start();
    for (int c = 1; c <= 4; c++) begin
      pc = pc + 32'd4;
      tick();
    end
    pc = pc + 32'd4;
    halt_req = 1'b1;
    push_snapshot();
    tick();
    halt_req = 1'b0;
    tick(); tick(); tick();
    chk("mid_idx", dif.dump_idx, 3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sb.delete();
    chk("mrst_valid", dif.dump_valid, 0);
    chk("mrst_idx", dif.dump_idx, 0);
    chk("mrst_data", dif.dump_data, 0);
    chk("mrst_running", running, 0);
    chk("mrst_done", done, 0);
    chk("mrst_status", status, 0);
    chk("mrst_cnt", cycle_cnt, 0);
    set_watch(32'h6000_0000);
    do_start();
    chk("fresh_running", running, 1);
    chk("fresh_cnt0", cycle_cnt, 0);
    for (int c = 1; c <= 2; c++) begin
      pc = pc + 32'd4;
      tick();
    end
    pc = pc + 32'd4;
    halt_req = 1'b1;
    push_snapshot();
    tick();
    halt_req = 1'b0;
    chk("fresh_status", status, 2'b01);
    chk("fresh_cnt", cycle_cnt, 3);
    wait_dump("fresh_dump_cycles", 8);
    chk("fresh_done", done, 1);

    // Single 64-bit channel build.
    watch2 = 64'hDEAD_BEEF_0123_4567;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    pc2 = 32'h100;
    tick();
    pc2 = 32'h104;
    halt2 = 1'b1;
    tick();
    halt2 = 1'b0;
    watch2 = 64'h1111_2222_3333_4444;
    chk("w64_valid", dif2.dump_valid, 1);
    chk("w64_idx", dif2.dump_idx, 0);
    chk("w64_data", dif2.dump_data, 64'hDEAD_BEEF_0123_4567);
    chk("w64_status", status2, 2'b01);
    chk("w64_cnt", cycle_cnt2, 2);
    tick();
    chk("w64_hold", dif2.dump_data, 64'hDEAD_BEEF_0123_4567);
    dif2.dump_ready = 1'b1;
    tick();
    chk("w64_done", done2, 1);
    chk("w64_valid_off", dif2.dump_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
